// File: rtl/crc_engine.sv
// crc_engine: bit-serial CRC generator/checker, STEP message bits per cycle.
// Valid/ready on both sides; the result is held until the consumer takes it.
module crc_engine #(
   parameter int DATA_W = 11,
   parameter int CRC_W  = 4,
   parameter int STEP   = 1,
   parameter logic [CRC_W-1:0] INIT = '0
) (
   input  logic                      Clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      mode,
   input  logic [DATA_W-1:0]         Data_in,
   input  logic [CRC_W:0]            polynomial,
   input  logic [CRC_W-1:0]          crc_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W+CRC_W-1:0]   crc_encoded_data,
   output logic [CRC_W-1:0]          remainder,
   output logic                      crc_ok,
   output logic                      busy
);

   localparam int NSTEP = DATA_W / STEP;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [CRC_W-1:0]  crc_reg;
   logic [CRC_W-1:0]  crc_nxt;
   logic [CRC_W-1:0]  poly_q;
   logic [CRC_W-1:0]  crc_in_q;
   logic [DATA_W-1:0] msg_q;
   logic [DATA_W-1:0] msg_sh;
   logic              mode_q;
   logic              fb;

   assign in_ready = (state == IDLE);
   assign busy     = (state == SHIFT);

   // msg_sh is consumed from its MSB; STEP bits folded per cycle
   always_comb begin
      crc_nxt = crc_reg;
      fb      = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         fb      = crc_nxt[CRC_W-1] ^ msg_sh[DATA_W-1-i];
         crc_nxt = (crc_nxt << 1) ^ (fb ? poly_q : '0);
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         crc_reg          <= '0;
         poly_q           <= '0;
         crc_in_q         <= '0;
         msg_q            <= '0;
         msg_sh           <= '0;
         mode_q           <= 1'b0;
         out_valid        <= 1'b0;
         remainder        <= '0;
         crc_encoded_data <= '0;
         crc_ok           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  msg_q    <= Data_in;
                  msg_sh   <= Data_in;
                  poly_q   <= polynomial[CRC_W-1:0];
                  mode_q   <= mode;
                  crc_in_q <= crc_in;
                  crc_reg  <= INIT;
                  cnt      <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               crc_reg <= crc_nxt;
               msg_sh  <= msg_sh << STEP;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt              <= '0;
                  state            <= DONE;
                  out_valid        <= 1'b1;
                  remainder        <= crc_nxt;
                  crc_encoded_data <= {msg_q, crc_nxt};
                  crc_ok           <= mode_q && (crc_nxt == crc_in_q);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed vectors against a GF(2) long-division model.
// Default instance plus two 14-bit/3-bit instances at STEP 1 and 2.
module tb_crc_engine;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        reset;
   logic        in_valid, mode, out_ready;
   logic [10:0] data_in;
   logic [4:0]  poly;
   logic [3:0]  crc_in;
   logic        in_ready, out_valid, crc_ok, busy;
   logic [14:0] enc;
   logic [3:0]  rem;

   logic        b_valid, b_mode;
   logic [13:0] b_data;
   logic [3:0]  b_poly;
   logic [2:0]  b_crcin;
   logic        b1_ready, b1_ov, b1_ok, b1_busy;
   logic        b2_ready, b2_ov, b2_ok, b2_busy;
   logic [16:0] b1_enc, b2_enc;
   logic [2:0]  b1_rem, b2_rem;

   crc_engine dut (
      .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .Data_in(data_in), .polynomial(poly), .crc_in(crc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .crc_encoded_data(enc), .remainder(rem), .crc_ok(crc_ok), .busy(busy)
   );

   crc_engine #(.DATA_W(14), .CRC_W(3), .STEP(1)) dut_s1 (
      .Clk(Clk), .reset(reset), .in_valid(b_valid), .in_ready(b1_ready),
      .mode(b_mode), .Data_in(b_data), .polynomial(b_poly), .crc_in(b_crcin),
      .out_valid(b1_ov), .out_ready(1'b1),
      .crc_encoded_data(b1_enc), .remainder(b1_rem), .crc_ok(b1_ok),
      .busy(b1_busy)
   );

   crc_engine #(.DATA_W(14), .CRC_W(3), .STEP(2)) dut_s2 (
      .Clk(Clk), .reset(reset), .in_valid(b_valid), .in_ready(b2_ready),
      .mode(b_mode), .Data_in(b_data), .polynomial(b_poly), .crc_in(b_crcin),
      .out_valid(b2_ov), .out_ready(1'b1),
      .crc_encoded_data(b2_enc), .remainder(b2_rem), .crc_ok(b2_ok),
      .busy(b2_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // remainder of (msg * x^cw) / poly by textbook long division
   function automatic logic [63:0] gf_rem(input logic [63:0] msg, input int dw,
                                          input logic [63:0] p, input int cw);
      logic [63:0] v;
      v = msg << cw;
      for (int b = dw + cw - 1; b >= cw; b--)
         if (v[b]) v = v ^ (p << (b - cw));
      return v & ((64'd1 << cw) - 64'd1);
   endfunction

   logic [3:0]  exp_rem;
   logic [14:0] exp_enc;
   logic        exp_ok;
   logic        exp_on = 1'b0;

   always @(negedge Clk) begin
      if (!reset && exp_on && out_valid) begin
         check("cmp_remainder", rem, exp_rem);
         check("cmp_encoded", enc, exp_enc);
         check("cmp_crc_ok", crc_ok, exp_ok);
         check("cmp_in_ready_low", in_ready, 1'b0);
         check("cmp_busy_low", busy, 1'b0);
      end
   end

   task automatic run0(input logic [10:0] d, input logic [4:0] p,
                       input logic m, input logic [3:0] ci,
                       input int hold, output int lat);
      @(negedge Clk);
      data_in = d; poly = p; mode = m; crc_in = ci;
      in_valid = 1'b1; out_ready = 1'b0;
      check("accept_in_ready", in_ready, 1'b1);
      exp_rem = 4'(gf_rem(64'(d), 11, 64'(p), 4));
      exp_enc = {d, exp_rem};
      exp_ok  = m && (exp_rem == ci);
      exp_on  = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      data_in = ~d; poly = 5'b11111; mode = ~m; crc_in = ~ci;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge Clk); #1;
         lat++;
      end
      if (!out_valid) check("result_timeout", out_valid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         data_in = 11'($urandom); in_valid = 1'b1;
         @(posedge Clk); #1;
         check("hold_out_valid", out_valid, 1'b1);
      end
      @(negedge Clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      check("release_out_valid", out_valid, 1'b0);
      check("release_in_ready", in_ready, 1'b1);
      check("idle_keeps_rem", rem, exp_rem);
      check("idle_keeps_enc", enc, exp_enc);
   endtask

   initial begin
      int lat;
      int l1, l2;
      logic [2:0]  r1, r2;
      logic [16:0] e1;

      reset = 1'b1;
      in_valid = 0; mode = 0; out_ready = 0; data_in = '0; poly = '0;
      crc_in = '0;
      b_valid = 0; b_mode = 0; b_data = '0; b_poly = '0; b_crcin = '0;
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_remainder", rem, 4'h0);
      check("rst_encoded", enc, 15'h0);
      check("rst_crc_ok", crc_ok, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge Clk);
      reset = 1'b0;
      #1 check("rst_in_ready", in_ready, 1'b1);

      run0(11'b10000000000, 5'b10011, 1'b0, 4'h0, 0, lat);
      check("enc_msb_latency", lat, 12);
      check("enc_msb_rem", rem, 4'b1001);
      check("enc_msb_enc", enc, 15'b100000000001001);
      check("enc_msb_ok", crc_ok, 1'b0);

      run0(11'b00000000001, 5'b10011, 1'b0, 4'h0, 0, lat);
      check("enc_lsb_rem", rem, 4'b0011);
      run0(11'b0, 5'b10011, 1'b0, 4'h0, 0, lat);
      check("enc_zero_rem", rem, 4'b0000);

      run0(11'b10000000000, 5'b10011, 1'b1, 4'b1001, 0, lat);
      check("chk_good_ok", crc_ok, 1'b1);
      run0(11'b10000000000, 5'b10011, 1'b1, 4'b1000, 0, lat);
      check("chk_bad_ok", crc_ok, 1'b0);
      check("chk_bad_rem", rem, 4'b1001);

      run0(11'b10110011101, 5'b10011, 1'b0, 4'h0, 5, lat);
      run0(11'b01111010001, 5'b11001, 1'b0, 4'h0, 0, lat);
      run0(11'b11111111111, 5'b10101, 1'b1, 4'h7, 2, lat);

      @(negedge Clk);
      data_in = 11'b10000000000; poly = 5'b10011; mode = 0; in_valid = 1;
      @(posedge Clk); #1;
      in_valid = 0;
      repeat (5) @(posedge Clk);
      #1 check("mid_shift_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_rem", rem, 4'h0);
      check("abort_enc", enc, 15'h0);
      check("abort_ok", crc_ok, 1'b0);
      @(negedge Clk);
      reset = 1'b0;
      run0(11'b10000000000, 5'b10011, 1'b0, 4'h0, 0, lat);
      check("rerun_latency", lat, 12);
      check("rerun_rem", rem, 4'b1001);
      check("rerun_enc", enc, 15'b100000000001001);

      @(negedge Clk);
      b_data = 14'b11010011101100; b_poly = 4'b1011; b_valid = 1'b1;
      check("s1_in_ready", b1_ready, 1'b1);
      check("s2_in_ready", b2_ready, 1'b1);
      @(posedge Clk); #1;
      b_valid = 1'b0; b_data = '1;
      l1 = 0; l2 = 0; r1 = '0; r2 = '0; e1 = '0;
      for (int e = 2; e <= 40; e++) begin
         @(posedge Clk); #1;
         if (b1_ov && l1 == 0) begin l1 = e; r1 = b1_rem; e1 = b1_enc; end
         if (b2_ov && l2 == 0) begin l2 = e; r2 = b2_rem; end
      end
      check("s1_latency", l1, 15);
      check("s2_latency", l2, 8);
      check("s1_rem", r1, 3'b100);
      check("s2_rem", r2, 3'b100);
      check("s1_model", r1, 3'(gf_rem(64'b11010011101100, 14, 64'b1011, 3)));
      check("s1_enc", e1, {14'b11010011101100, 3'b100});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 11: message width in bits.
REQ-002 SHALL have parameter CRC_W, default 4: CRC width, equal to the polynomial degree.
REQ-003 SHALL have parameter STEP, default 1: message bits consumed per cycle; DATA_W mod STEP SHALL be 0.
REQ-004 SHALL have parameter INIT, default 0: CRC_W-bit register preset.
REQ-005 SHALL have port Clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: request present.
REQ-008 SHALL have port in_ready, output, 1 bit: engine accepts a request.
REQ-009 SHALL have port mode, input, 1 bit: 0 = encode, 1 = check.
REQ-010 SHALL have port Data_in, input, DATA_W bits: message, MSB first.
REQ-011 SHALL have port polynomial, input, CRC_W+1 bits: full generator; MSB is implicit 1 and ignored.
REQ-012 SHALL have port crc_in, input, CRC_W bits: received CRC, used in check mode only.
REQ-013 SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port crc_encoded_data, output, DATA_W+CRC_W bits: {message, remainder}.
REQ-016 SHALL have port remainder, output, CRC_W bits: computed CRC.
REQ-017 SHALL have port crc_ok, output, 1 bit: check mode, remainder == crc_in.
REQ-018 SHALL have port busy, output, 1 bit: high in SHIFT state.

Function
REQ-019 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-020 in_ready SHALL be high only in IDLE.
REQ-021 Acceptance SHALL occur when in_valid && in_ready at a rising edge.
REQ-022 On acceptance, the engine SHALL latch Data_in, polynomial low CRC_W bits, mode and crc_in; load crc_reg = INIT; clear the step counter; and go to SHIFT.
REQ-023 Inputs SHALL be ignored outside acceptance; input changes during SHIFT SHALL NOT affect the result.
REQ-024 In SHIFT, each cycle SHALL process the next STEP message bits MSB-first, each bit: fb = crc_reg[MSB] ^ bit; crc_reg = (crc_reg << 1) ^ (fb ? poly : 0); truncated to CRC_W bits.
REQ-025 The result SHALL equal the remainder of (message * x^CRC_W) divided by polynomial over GF(2) when INIT = 0.
REQ-026 The step counter SHALL count 0 .. DATA_W/STEP-1; after the last step the FSM SHALL go to DONE; SHIFT SHALL last exactly DATA_W/STEP cycles.
REQ-027 On DONE entry, the engine SHALL register out_valid=1, remainder=crc_reg, crc_encoded_data={latched message, crc_reg} and crc_ok=(mode==1 && crc_reg==latched crc_in).
REQ-028 Latency from the acceptance edge to out_valid high SHALL be DATA_W/STEP+1 edges.
REQ-029 Outputs SHALL hold stable while out_valid && !out_ready (back-pressure, unbounded).
REQ-030 On out_valid && out_ready, the engine SHALL clear out_valid and return to IDLE; in_ready SHALL rise the next cycle (no same-cycle restart).
REQ-031 In encode mode, crc_ok SHALL be 0.
REQ-032 remainder, crc_encoded_data and crc_ok SHALL keep their last values in IDLE until the next DONE.
REQ-033 An all-zero message with INIT = 0 SHALL give remainder 0.

Reset
REQ-034 reset high SHALL asynchronously force IDLE, counter 0, crc_reg 0, out_valid 0, busy 0, crc_ok 0, remainder 0 and crc_encoded_data 0; in_ready SHALL be 1 after release.
REQ-035 reset mid-SHIFT or in DONE SHALL abort the operation and drop the result; the first accept after release SHALL compute from INIT.

Verification
REQ-036 Defaults, encode, Data_in=11'b10000000000, polynomial=5'b10011 -> remainder 4'b1001, crc_encoded_data 15'b100000000001001, out_valid at edge 12 after accept.
REQ-037 Defaults, encode, Data_in=11'b00000000001, polynomial=5'b10011 -> remainder 4'b0011; Data_in=0 -> 4'b0000.
REQ-038 DATA_W=14, CRC_W=3, STEP=1 then STEP=2, Data_in=14'b11010011101100, polynomial=4'b1011 -> remainder 3'b100 in both cases; latency 15 vs 8 edges.
REQ-039 Check mode with the REQ-036 data and crc_in=4'b1001 -> crc_ok=1; crc_in=4'b1000 -> crc_ok=0.
REQ-040 Hold out_ready=0 for 5 cycles in DONE while changing Data_in and asserting in_valid -> outputs stable, in_ready 0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-041 Assert reset at SHIFT cycle 5 -> all outputs 0 immediately; rerun of REQ-036 -> identical result.
